// File: rtl/prueba1_ram_tester_pkg.sv
// Shared types and encodings for the RAM tester master: FSM states, mode
// codes and the fixed byte-enable value.
package prueba1_ram_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_REQ,
        ST_READ_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_FILL        = 2'd0;
    localparam logic [1:0] MODE_FILL_VERIFY = 2'd1;
    localparam logic [1:0] MODE_VERIFY      = 2'd2;

    localparam logic [3:0] BE_ALL = 4'hF;

    // Modes 0 and 1 begin with a fill pass; 2 and the reserved 3 go straight to verify.
    function automatic logic mode_writes(input logic [1:0] m);
        return (m == MODE_FILL) || (m == MODE_FILL_VERIFY);
    endfunction

endpackage

// File: rtl/prueba1_ram_tester_pattern.sv
// Word index counter plus the address and expected-data generator for the
// RAM tester: word i lives at (base & ~3) + 4*i (wrapping) and holds seed + i.
module prueba1_ram_tester_pattern
    import prueba1_ram_tester_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              rewind,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    input  logic [31:0]       seed,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data,
    output logic              last
);

    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  count_r;
    logic [31:0]       seed_r;
    logic [CNT_W-1:0]  idx;
    logic [ADDR_W-1:0] offset;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r  <= '0;
            count_r <= '0;
            seed_r  <= '0;
            idx     <= '0;
        end else if (load) begin
            base_r  <= {base[ADDR_W-1:2], 2'b00};
            count_r <= count;
            seed_r  <= seed;
            idx     <= '0;
        end else if (rewind) begin
            idx <= '0;
        end else if (advance) begin
            idx <= idx + CNT_W'(1);
        end
    end

    // Truncating the byte offset to ADDR_W makes the address wrap at the top of the space.
    assign offset = ADDR_W'({idx, 2'b00});
    assign addr   = base_r + offset;
    assign data   = seed_r + 32'(idx);
    assign last   = (idx == count_r - CNT_W'(1));

endmodule

// File: rtl/prueba1_ram_tester.sv
// Avalon-MM master that fills a RAM word range with seed+i, verifies it, or
// both, and reports pass/fail, abort and the first failing address/data.
module prueba1_ram_tester
    import prueba1_ram_tester_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    input  logic [31:0]       seed,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aborted,
    output logic [ADDR_W-1:0] err_addr,
    output logic [31:0]       err_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    state_t            state, state_nxt;
    logic [1:0]        mode_r;
    logic              pat_load, pat_rewind, pat_advance;
    logic              set_err, set_abort;
    logic [ADDR_W-1:0] pat_addr;
    logic [31:0]       pat_data;
    logic              pat_last;

    prueba1_ram_tester_pattern #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_pattern (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pat_load),
        .rewind  (pat_rewind),
        .advance (pat_advance),
        .base    (base),
        .count   (count),
        .seed    (seed),
        .addr    (pat_addr),
        .data    (pat_data),
        .last    (pat_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Requests are only ever left on a bus accept; abort is honoured at transfer boundaries.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt   = state;
        pat_load    = 1'b0;
        pat_rewind  = 1'b0;
        pat_advance = 1'b0;
        set_err     = 1'b0;
        set_abort   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pat_load = 1'b1;
                    if (count == '0)            state_nxt = ST_DONE;
                    else if (mode_writes(mode)) state_nxt = ST_WRITE;
                    else                        state_nxt = ST_READ_REQ;
                end
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
                    if (pat_last && mode_r != MODE_FILL_VERIFY) begin
                        state_nxt = ST_DONE;
                    end else if (abort) begin
                        set_abort = 1'b1;
                        state_nxt = ST_DONE;
                    end else if (pat_last) begin
                        pat_rewind = 1'b1;
                        state_nxt  = ST_READ_REQ;
                    end else begin
                        pat_advance = 1'b1;
                    end
                end
            end
            ST_READ_REQ: begin
                if (!avm_waitrequest) state_nxt = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                if (avm_readdatavalid) begin
                    if (avm_readdata != pat_data) begin
                        set_err   = 1'b1;
                        state_nxt = ST_DONE;
                    end else if (pat_last) begin
                        state_nxt = ST_DONE;
                    end else if (abort) begin
                        set_abort = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        pat_advance = 1'b1;
                        state_nxt   = ST_READ_REQ;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state == ST_WRITE) || (state == ST_READ_REQ) || (state == ST_READ_WAIT);
        done           = (state == ST_DONE);
        avm_write      = (state == ST_WRITE);
        avm_read       = (state == ST_READ_REQ);
        avm_byteenable = (avm_write || avm_read) ? BE_ALL : 4'h0;
        avm_address    = (avm_write || avm_read) ? pat_addr : '0;
        avm_writedata  = avm_write ? pat_data : '0;
    end

    // Status is cleared by an accepted start and otherwise only ever set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r   <= MODE_FILL;
            error    <= 1'b0;
            aborted  <= 1'b0;
            err_addr <= '0;
            err_data <= '0;
        end else if (pat_load) begin
            mode_r   <= (mode == 2'd3) ? MODE_VERIFY : mode;
            error    <= 1'b0;
            aborted  <= 1'b0;
            err_addr <= '0;
            err_data <= '0;
        end else begin
            if (set_err) begin
                error    <= 1'b1;
                err_addr <= pat_addr;
                err_data <= avm_readdata;
            end
            if (set_abort) aborted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prueba1_ram_tester.sv
// Self-checking bench for prueba1_ram_tester: a RAM slave with programmable
// stalls and read latency, plus a word-level reference model of each run.
module tb_prueba1_ram_tester;
    import prueba1_ram_tester_pkg::*;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 11;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [ADDR_W-1:0] base = '0;
    logic [CNT_W-1:0]  count = '0;
    logic [31:0]       seed = '0;
    logic              busy, done, error, aborted;
    logic [ADDR_W-1:0] err_addr;
    logic [31:0]       err_data;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read, avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    prueba1_ram_tester #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .mode              (mode),
        .base              (base),
        .count             (count),
        .seed              (seed),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .aborted           (aborted),
        .err_addr          (err_addr),
        .err_data          (err_data),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    // ---------------- RAM slave ----------------
    logic [31:0]       mem [1024] = '{default: 32'h0};
    int                stall_plan [16];
    bit                rand_stall = 1'b0;
    int                rd_lat = 1;
    int                stall_left = 0;
    int                xfer_no = 0;
    int                rd_cnt = 0;
    logic [31:0]       rd_word = '0;
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];
    logic [ADDR_W-1:0] rd_addr_q [$];
    bit                poke_req = 1'b0;
    logic [9:0]        poke_idx = '0;
    logic [31:0]       poke_data = '0;

    assign avm_waitrequest   = (avm_read || avm_write) && (stall_left > 0);
    assign avm_readdatavalid = (rd_cnt == 1);
    assign avm_readdata      = rd_word;

    function automatic int next_stall(input int n);
        if (rand_stall) return int'($urandom_range(0, 2));
        return (n < 16) ? stall_plan[n] : 0;
    endfunction

    function automatic int pick_lat();
        return (rd_lat > 0) ? rd_lat : int'($urandom_range(1, 4));
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            rd_cnt     <= 0;
            stall_left <= 0;
        end else begin
            if (poke_req) mem[poke_idx] <= poke_data;
            if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
            if (start && !busy) begin
                xfer_no    <= 0;
                stall_left <= next_stall(0);
            end else if (avm_read || avm_write) begin
                if (stall_left > 0) begin
                    stall_left <= stall_left - 1;
                end else begin
                    xfer_no    <= xfer_no + 1;
                    stall_left <= next_stall(xfer_no + 1);
                    if (avm_write) begin
                        mem[avm_address[11:2]] <= avm_writedata;
                        wr_addr_q.push_back(avm_address);
                        wr_data_q.push_back(avm_writedata);
                    end else begin
                        rd_addr_q.push_back(avm_address);
                        rd_word <= mem[avm_address[11:2]];
                        rd_cnt  <= pick_lat();
                    end
                end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int                proto_err = 0;
    logic              prev_stalled = 1'b0;
    logic              prev_rd = 1'b0, prev_wr = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0]       prev_data = '0;
    wire               req      = avm_read | avm_write;
    wire               be_bad   = req ? (avm_byteenable != 4'hF) : (avm_byteenable != 4'h0);
    wire               both     = avm_read & avm_write;
    wire               unstable = prev_stalled && ((avm_read != prev_rd) || (avm_write != prev_wr) ||
                                  (avm_address != prev_addr) || (avm_writedata != prev_data));

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stalled <= 1'b0;
        end else begin
            proto_err    <= proto_err + int'(be_bad) + int'(both) + int'(unstable);
            prev_stalled <= req && avm_waitrequest;
            prev_rd      <= avm_read;
            prev_wr      <= avm_write;
            prev_addr    <= avm_address;
            prev_data    <= avm_writedata;
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]       rm [1024];
    int                exp_nwr, exp_nrd, exp_cyc;
    bit                exp_err, exp_abt;
    logic [ADDR_W-1:0] exp_ea;
    logic [31:0]       exp_ed;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b, input int i);
        logic [ADDR_W-1:0] a;
        a = {b[ADDR_W-1:2], 2'b00};
        return a + ADDR_W'(4 * i);
    endfunction

    // Predicts a whole run from the word-level rules; abort_after = writes accepted before abort rises.
    task automatic model(input logic [1:0] m, input logic [ADDR_W-1:0] b, input int n,
                         input logic [31:0] s, input int abort_after);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 1024; i++) rm[i] = mem[i];
        exp_nwr = 0; exp_nrd = 0; exp_err = 0; exp_abt = 0; exp_ea = '0; exp_ed = '0;
        if (n > 0 && (m == 2'd0 || m == 2'd1)) begin
            exp_nwr = (abort_after >= 0 && abort_after + 1 < n) ? abort_after + 1 : n;
            for (int i = 0; i < exp_nwr; i++) begin
                a = word_addr(b, i);
                rm[a[11:2]] = s + 32'(i);
            end
            exp_abt = (abort_after >= 0) && !(exp_nwr == n && m == 2'd0);
        end
        if (n > 0 && m != 2'd0 && !exp_abt) begin
            for (int i = 0; i < n; i++) begin
                a = word_addr(b, i);
                exp_nrd++;
                if (rm[a[11:2]] != s + 32'(i)) begin
                    exp_err = 1;
                    exp_ea  = a;
                    exp_ed  = rm[a[11:2]];
                    break;
                end
            end
        end
        exp_cyc = 1 + exp_nwr + 2 * exp_nrd;
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [ADDR_W-1:0] b,
                          input int n, input logic [31:0] s, input int abort_after,
                          input bit chk_cyc, input int restart_at);
        int lw, lr, cyc;
        bit seen;
        model(m, b, n, s, abort_after);
        lw = wr_addr_q.size();
        lr = rd_addr_q.size();
        @(negedge clk);
        mode = m; base = b; count = CNT_W'(n); seed = s; start = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == restart_at) begin
                start = 1'b1; mode = 2'd3; base = ~b; count = 11'd5; seed = ~s;
            end
            if (abort_after >= 0 && (wr_addr_q.size() - lw) >= abort_after) abort = 1'b1;
            if (cyc == 1 && n > 0) check({tag, " busy_first"}, 32'(busy), 1);
            if (done) seen = 1;
        end
        start = 1'b0;
        abort = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 1);
        check({tag, " busy_at_done"}, 32'(busy), 0);
        if (chk_cyc) check({tag, " done_cycle"}, cyc, exp_cyc);
        check({tag, " error"}, 32'(error), 32'(exp_err));
        check({tag, " aborted"}, 32'(aborted), 32'(exp_abt));
        if (exp_err) begin
            check({tag, " err_addr"}, 32'(err_addr), 32'(exp_ea));
            check({tag, " err_data"}, err_data, exp_ed);
        end
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 0);
        repeat (3) @(negedge clk);
        check({tag, " n_writes"}, wr_addr_q.size() - lw, exp_nwr);
        check({tag, " n_reads"}, rd_addr_q.size() - lr, exp_nrd);
        for (int i = 0; i < exp_nwr && lw + i < wr_addr_q.size(); i++) begin
            check({tag, $sformatf(" wr_addr[%0d]", i)}, 32'(wr_addr_q[lw + i]), 32'(word_addr(b, i)));
            check({tag, $sformatf(" wr_data[%0d]", i)}, wr_data_q[lw + i], s + 32'(i));
        end
        for (int i = 0; i < exp_nrd && lr + i < rd_addr_q.size(); i++)
            check({tag, $sformatf(" rd_addr[%0d]", i)}, 32'(rd_addr_q[lr + i]), 32'(word_addr(b, i)));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " error"}, 32'(error), 0);
        check({tag, " aborted"}, 32'(aborted), 0);
        check({tag, " avm_read"}, 32'(avm_read), 0);
        check({tag, " avm_write"}, 32'(avm_write), 0);
        check({tag, " avm_be"}, 32'(avm_byteenable), 0);
        check({tag, " err_addr"}, 32'(err_addr), 0);
        check({tag, " err_data"}, err_data, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_idx = a[11:2]; poke_data = d; poke_req = 1'b1;
        @(negedge clk);
        poke_req = 1'b0;
    endtask

    task automatic set_plan(input int v);
        for (int i = 0; i < 16; i++) stall_plan[i] = v;
    endtask

    initial begin
        int lr0;
        bit seen;
        logic [ADDR_W-1:0] rb;
        logic [31:0] rs;
        int rn;
        set_plan(0);

        #1 reset_pulse("reset");

        run_op("fill_verify", 2'd1, 12'h100, 4, 32'hA5A50000, -1, 1, 0);

        stall_plan[1] = 2;
        stall_plan[3] = 2;
        run_op("stalled", 2'd1, 12'h200, 3, 32'h0BAD0000, -1, 0, 0);
        set_plan(0);

        run_op("prefill", 2'd0, 12'h000, 8, 32'h11110000, -1, 1, 0);
        poke(12'h010, 32'hDEADBEEF);
        run_op("verify_bad", 2'd2, 12'h000, 8, 32'h11110000, -1, 1, 0);
        reset_pulse("reset_after_err");

        run_op("wrap", 2'd0, 12'hFF8, 4, 32'hCAFE0000, -1, 1, 0);

        set_plan(2);
        run_op("abort", 2'd1, 12'h300, 6, 32'h77770000, 1, 0, 0);
        set_plan(0);
        run_op("count0", 2'd1, 12'h400, 0, 32'h1, -1, 1, 0);

        // Reset while a read is outstanding.
        rd_lat = 8;
        lr0 = rd_addr_q.size();
        @(negedge clk);
        mode = 2'd2; base = 12'h000; count = 11'd4; seed = 32'h11110000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rd_addr_q.size() > lr0) seen = 1;
            else @(negedge clk);
        end
        check("rw_read_issued", 32'(seen), 1);
        check("rw_busy_before", 32'(busy), 1);
        reset_pulse("reset_read_wait");
        rd_lat = 1;

        rand_stall = 1;
        run_op("after_reset", 2'd1, 12'h500, 8, 32'h5A5A5A5A, -1, 0, 3);

        rd_lat = 0;
        for (int it = 0; it < 6; it++) begin
            rb = ADDR_W'($urandom);
            rs = $urandom;
            rn = int'($urandom_range(1, 20));
            run_op($sformatf("rnd%0d_fill", it), 2'd0, rb, rn, rs, -1, 0, 0);
            if ($urandom_range(0, 1) == 1) poke(word_addr(rb, int'($urandom_range(0, rn - 1))), $urandom);
            run_op($sformatf("rnd%0d_op", it), 2'($urandom_range(1, 3)), rb, rn, rs, -1, 0, 0);
        end

        check("protocol", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/prueba1_ram_tester.md
# prueba1_ram_tester

Avalon-MM master that exercises the on-chip 32-bit RAM slave: fills a word range with an incrementing pattern, reads it back and compares, or does either step alone. Sits in the Nios system beside the CPU as a second master on the RAM's interconnect. Used for power-on memory self-test and for the alarm firmware's periodic RAM check; reports pass/fail and the first failing address.

## Interface
Parameters:
- ADDR_W, 12, master byte-address width (1024 words × 4 bytes)
- CNT_W, 11, word-count width (0..1024)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  0 = fill, 1 = fill then verify, 2 = verify, 3 = reserved (treated as 2)
- base  in  ADDR_W  start byte address; bits [1:0] ignored
- count  in  CNT_W  number of 32-bit words
- seed  in  32  pattern seed
- abort  in  1  level; stop at next transfer boundary
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion
- error  out  1  set on first mismatch; held until next start
- aborted  out  1  set when ended by abort; held until next start
- err_addr  out  ADDR_W  byte address of first mismatch
- err_data  out  32  readdata at first mismatch
- avm_address  out  ADDR_W  byte address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  4  always 4'hF while read or write is asserted, else 0
- avm_writedata  out  32  write data
- avm_waitrequest  in  1  interconnect stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier

## Operation
- Word i (0..count−1): address = (base & ~3) + 4·i mod 2^ADDR_W (wraps); data = seed + i mod 2^32.
- States: IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
- IDLE: start=1 latches mode/base/count/seed, clears error/aborted/err_*, sets busy. count=0 → DONE. Mode 0/1 → WRITE; mode 2/3 → READ_REQ.
- WRITE: avm_write=1 with word i. Held with address/data stable while waitrequest=1. On accept (waitrequest=0): i++; after last word, mode 1 → READ_REQ with i=0, else → DONE.
- READ_REQ: avm_read=1 held while waitrequest=1; on accept → READ_WAIT. One outstanding read maximum.
- READ_WAIT: on readdatavalid compare with expected. Mismatch → error=1, err_addr/err_data captured, → DONE. Match and last word → DONE; otherwise i++ → READ_REQ.
- abort: checked only at transfer boundaries (write accept, readdatavalid). If high there and the operation is not finished → aborted=1, → DONE. A request already asserted is never withdrawn before acceptance.
- DONE: done=1 for one cycle, busy=0 in same cycle, → IDLE.
- start while busy: ignored. Mismatch on the last word: error wins; aborted stays 0.
- Reset: all outputs 0, state IDLE, counters cleared, immediately (asynchronous), including mid-transfer.

## Timing
- start sampled at edge k; busy and first avm_write/avm_read asserted from cycle k+1.
- Zero wait states: one write per cycle; each verify word 2 cycles (request, then readdatavalid).
- Readdatavalid latency is arbitrary ≥1 cycle; READ_WAIT waits indefinitely.
- Mode 1, N words, no stalls: done pulse N + 2N + 1 cycles after start edge.
- count=0: done pulse in cycle k+1, no bus activity.
- error/err_* valid no later than the done cycle.

## Structure
- Package prueba1_ram_tester_pkg: state enum, mode encodings (MODE_FILL, MODE_FILL_VERIFY, MODE_VERIFY), BE_ALL = 4'hF.
- One sub-module natural: prueba1_ram_tester_pattern (index counter, address wrap, expected-data generation); FSM and Avalon handshake stay in the top.

## Test plan
- Mode 1, base 0x100, count 4, seed 0xA5A50000, zero wait states → writes 0xA5A50000..03 at 0x100..0x10C, four matching reads, done 13 cycles after start, error=0.
- Mode 1, count 3, waitrequest held high 2 cycles on second write and first read → address/data stable during stalls, no lost or duplicate transfers, error=0.
- Mode 2, count 8, RAM word at 0x010 corrupted to 0xDEADBEEF → error=1, err_addr=0x010, err_data=0xDEADBEEF, no reads issued after 0x010.
- Mode 0, base 0xFF8, count 4 → writes to 0xFF8, 0xFFC, 0x000, 0x004 (wrap), no reads.
- abort raised during second of 6 stalled writes → that write completes, aborted=1, done pulse, no further requests; count=0 start → done next cycle, no bus activity.
- reset_n low mid-READ_WAIT → avm_read/write, busy, done, error drop immediately; next start runs cleanly; start while busy has no effect.
